// File: rtl/noc_arb_pkg.sv
// Shared definitions for the router local-port arbiters: FSM encodings,
// default sizes and the round-robin index helper.
package noc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ_DN = 2'b01,
    ACK_UP = 2'b10
  } state_t;

  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned DEF_DATA_W   = 32;

  // Index that follows cur in a ring of n requesters.
  function automatic int unsigned rr_next_idx(input int unsigned cur, input int unsigned n);
    return (cur + 1) % n;
  endfunction

endpackage

// File: rtl/local_port_injection_arbiter_if.sv
// Upstream injector and downstream Local-port handshake bundle.
interface local_port_injection_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned dataWidth = 32,
  parameter int unsigned CNT_W     = 16
);
  logic [NUM_REQ-1:0]           ReqUpStr;
  logic [NUM_REQ*dataWidth-1:0] PacketIn;
  logic [NUM_REQ-1:0]           GntUpStr;
  logic                         ReqDnStr;
  logic                         GntDnStr;
  logic                         DnStrFull;
  logic [dataWidth-1:0]         PacketOut;
  logic [IDX_W-1:0]             GrantIdx;
  logic                         Busy;
  logic [CNT_W-1:0]             PktCount;

  modport master (
    input  ReqUpStr, PacketIn, GntDnStr, DnStrFull,
    output GntUpStr, ReqDnStr, PacketOut, GrantIdx, Busy, PktCount
  );

  modport slave (
    output ReqUpStr, PacketIn, GntDnStr, DnStrFull,
    input  GntUpStr, ReqDnStr, PacketOut, GrantIdx, Busy, PktCount
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request scanning upward from
// the slot after last_grant, wrapping.
module rr_priority_picker
  import noc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  always_comb begin
    int unsigned cand;
    winner = '0;
    valid  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = rr_next_idx(32'(last_grant) + k, NUM_REQ);
      if (!valid && req[cand]) begin
        winner = IDX_W'(cand);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/local_port_injection_arbiter.sv
// Shares one router Local input port between NUM_REQ injectors: round-robin
// upstream arbitration, packet latch and downstream Req/Gnt handshake.
module local_port_injection_arbiter
  import noc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned dataWidth = DEF_DATA_W,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  local_port_injection_arbiter_if.master bus
);

  state_t               state, state_nxt;
  logic                 req_dn, req_dn_nxt;
  logic [NUM_REQ-1:0]   gnt_up, gnt_up_nxt;
  logic [dataWidth-1:0] pkt, pkt_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [IDX_W-1:0]     last, last_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     win;
  logic                 win_vld;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (bus.ReqUpStr),
    .last_grant (last),
    .winner     (win),
    .valid      (win_vld)
  );

  // last resets to NUM_REQ-1 so requester 0 holds first priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      req_dn <= 1'b0;
      gnt_up <= '0;
      pkt    <= '0;
      idx    <= '0;
      last   <= IDX_W'(NUM_REQ - 1);
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      req_dn <= req_dn_nxt;
      gnt_up <= gnt_up_nxt;
      pkt    <= pkt_nxt;
      idx    <= idx_nxt;
      last   <= last_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_dn_nxt = req_dn;
    gnt_up_nxt = '0;
    pkt_nxt    = pkt;
    idx_nxt    = idx;
    last_nxt   = last;
    cnt_nxt    = cnt;
    case (state)
      IDLE: begin
        if (win_vld && !bus.DnStrFull) begin
          pkt_nxt    = bus.PacketIn[win*dataWidth +: dataWidth];
          idx_nxt    = win;
          req_dn_nxt = 1'b1;
          state_nxt  = REQ_DN;
        end
      end
      REQ_DN: begin
        if (bus.GntDnStr) begin
          req_dn_nxt = 1'b0;
          gnt_up_nxt = NUM_REQ'(1) << idx;
          cnt_nxt    = cnt + CNT_W'(1);
          state_nxt  = ACK_UP;
        end
      end
      ACK_UP: begin
        // Wait for the winner to drop its request so it is never re-arbitrated
        if (!bus.ReqUpStr[idx]) begin
          last_nxt  = idx;
          state_nxt = IDLE;
        end
      end
      default: begin
        req_dn_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  assign bus.ReqDnStr  = req_dn;
  assign bus.GntUpStr  = gnt_up;
  assign bus.PacketOut = pkt;
  assign bus.GrantIdx  = idx;
  assign bus.PktCount  = cnt;
  assign bus.Busy      = (state != IDLE);

endmodule
